// File: rtl/sps_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sps_pkg
// Purpose  : Shared constants and types for the parking slot timer.
// Revision : 1.0 - initial release
// ============================================================================
package sps_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int TIME_W    = 6;
  localparam int MAX_MIN   = 59;
  localparam int MAX_SEC   = 59;

  // Display state: capacity view or a departing car's parked time
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SHOW = 1'b1
  } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/slot_timer.sv
`default_nettype none
// ============================================================================
// Module   : slot_timer
// Purpose  : Elapsed-time counter for one parking slot (min:sec, saturating
//            at 59:59). park/leave are already decoded for this slot.
// Revision : 1.0 - initial release
// ============================================================================
module slot_timer
  import sps_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              park,
  input  logic              leave,
  output logic              run,
  output logic [TIME_W-1:0] mins,
  output logic [TIME_W-1:0] secs
);

  // Start, stop and advance this slot's elapsed time. A park that coincides
  // with a leave of the running car restarts the slot for the new car; a
  // park always wins over a tick so a new car starts at exactly 00:00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run  <= 1'b0;
      mins <= '0;
      secs <= '0;
    end else if (park && (!run || leave)) begin
      run  <= 1'b1;
      mins <= '0;
      secs <= '0;
    end else if (leave && run) begin
      run  <= 1'b0;
      mins <= '0;
      secs <= '0;
    end else if (tick && run) begin
      if (secs != TIME_W'(MAX_SEC)) begin
        secs <= secs + TIME_W'(1);
      end else if (mins != TIME_W'(MAX_MIN)) begin
        secs <= '0;
        mins <= mins + TIME_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/parking_timer.sv
`default_nettype none
// ============================================================================
// Module   : parking_timer
// Purpose  : Four-slot parking timer. Each slot counts its car's parked time;
//            on departure the time is shown for SHOW_SECONDS ticks.
// Revision : 1.0 - initial release
// ============================================================================
module parking_timer
  import sps_pkg::*;
#(
  parameter int SHOW_SECONDS = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1Hz,
  input  logic              park_pulse,
  input  logic [SLOT_W-1:0] park_slot,
  input  logic              leave_pulse,
  input  logic [SLOT_W-1:0] leave_slot,
  output logic              mode,
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] seconds,
  output logic [NUM_SLOTS-1:0] timing
);

  localparam int SHOW_W = $clog2(SHOW_SECONDS + 1);

  logic [NUM_SLOTS-1:0] slot_run;
  logic [TIME_W-1:0]    slot_min [NUM_SLOTS];
  logic [TIME_W-1:0]    slot_sec [NUM_SLOTS];
  logic                 valid_leave;
  logic [TIME_W-1:0]    cap_min;
  logic [TIME_W-1:0]    cap_sec;
  disp_state_t          state;
  logic [SHOW_W-1:0]    show_cnt;

  generate
    for (genvar n = 0; n < NUM_SLOTS; n++) begin : g_slot
      slot_timer u_slot (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_1Hz),
        .park  (park_pulse && (park_slot == SLOT_W'(n))),
        .leave (leave_pulse && (leave_slot == SLOT_W'(n))),
        .run   (slot_run[n]),
        .mins  (slot_min[n]),
        .secs  (slot_sec[n])
      );
    end
  endgenerate

  // Only a departure from an occupied slot reaches the display; the
  // captured time is the slot's value before this cycle's tick.
  assign valid_leave = leave_pulse && slot_run[leave_slot];
  assign cap_min     = slot_min[leave_slot];
  assign cap_sec     = slot_sec[leave_slot];

  // Run flags are registers inside the slot timers, so timing is registered
  assign timing = slot_run;

  // Display FSM: a valid departure (re)enters SHOW; SHOW ends on the tick
  // that exhausts the show counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mode     <= 1'b0;
      minutes  <= '0;
      seconds  <= '0;
      show_cnt <= '0;
    end else if (valid_leave) begin
      state    <= SHOW;
      mode     <= 1'b1;
      minutes  <= cap_min;
      seconds  <= cap_sec;
      show_cnt <= SHOW_W'(SHOW_SECONDS);
    end else begin
      case (state)
        SHOW: begin
          if (tick_1Hz) begin
            if (show_cnt <= SHOW_W'(1)) begin
              state    <= IDLE;
              mode     <= 1'b0;
              minutes  <= '0;
              seconds  <= '0;
              show_cnt <= '0;
            end else begin
              show_cnt <= show_cnt - SHOW_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          mode    <= 1'b0;
          minutes <= '0;
          seconds <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/parking_timer.md
PARKING_TIMER -- requirements
Module: parking_timer

Interface
REQ-001 Parameter SHOW_SECONDS, default 5: number of 1 Hz ticks that a departing car's parked time stays on display.
REQ-002 Port clk, input, 1: system clock; the only clock in the block.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port tick_1Hz, input, 1: single-clk-cycle enable pulse, once per second, synchronous to clk.
REQ-005 Port park_pulse, input, 1: single-cycle pulse; a car has taken slot park_slot.
REQ-006 Port park_slot, input, 2: index of the slot being taken; valid while park_pulse=1.
REQ-007 Port leave_pulse, input, 1: single-cycle pulse; the car in slot leave_slot departs.
REQ-008 Port leave_slot, input, 2: index of the slot being vacated; valid while leave_pulse=1.
REQ-009 Port mode, output, 1: display select to the display stage; 0 = capacity view, 1 = time view.
REQ-010 Port minutes, output, 6: displayed minutes, 0-59.
REQ-011 Port seconds, output, 6: displayed seconds, 0-59.
REQ-012 Port timing, output, 4: bit n=1 while slot n's timer runs.

Function
REQ-013 The block SHALL keep per slot n (0-3): run flag, sec counter (0-59), min counter (0-59).
REQ-014 park_pulse to an idle slot SHALL set run, clear min:sec to 00:00, and update timing[n] on the next clk edge.
REQ-015 park_pulse to a running slot SHALL be ignored.
REQ-016 On tick_1Hz, each running slot SHALL step its time:
- sec+1 when sec<59;
- sec 59 -> 0 with min+1;
- 59:59 saturates (no wrap).
REQ-017 A slot parked in the same cycle as tick_1Hz SHALL hold 00:00 (no tick applied).
REQ-018 The display FSM SHALL have exactly two states, IDLE and SHOW.
REQ-019 IDLE SHALL drive mode=0, minutes=0, seconds=0.
REQ-020 leave_pulse to a running slot SHALL, on the next clk edge:
- latch that slot's pre-tick time into minutes/seconds;
- clear the slot's run flag and counters;
- load the show counter with SHOW_SECONDS;
- enter SHOW with mode=1.
REQ-021 leave_pulse to an idle slot SHALL be ignored, with no state or output change.
REQ-022 In SHOW, each tick_1Hz SHALL decrement the show counter.
REQ-023 The tick that brings the show counter to 0 SHALL cause a return to IDLE on that edge; mode=1 SHALL last exactly SHOW_SECONDS ticks.
REQ-024 A valid leave_pulse during SHOW SHALL relatch the new time and reload the show counter to SHOW_SECONDS.
REQ-025 If park_pulse and leave_pulse name the same running slot in one cycle:
- the leave SHALL be processed (time captured);
- the slot SHALL restart at 00:00 with run=1.
REQ-026 Simultaneous park and leave on different slots SHALL both take effect in the same cycle.
REQ-027 All outputs SHALL be registered; latency from any input pulse to the output change SHALL be one clk cycle.

Reset
REQ-028 Asserting reset (0) SHALL immediately clear all of the following, regardless of clk:
- run flags, counters and show counter;
- timing = 4'b0000;
- state = IDLE, mode = 0, minutes = 0, seconds = 0.
REQ-029 Reset asserted mid-SHOW or mid-count SHALL discard all captured and running times; no pulse is honoured until reset deasserts.

Structure
REQ-030 Shared package sps_pkg SHALL hold:
- NUM_SLOTS = 4;
- MAX_MIN = 59 and MAX_SEC = 59;
- the IDLE/SHOW state type.
REQ-031 The per-slot run/min/sec logic SHALL be one sub-module, slot_timer, instantiated NUM_SLOTS times; capture mux and display FSM stay in parking_timer.

Verification
REQ-032 Park slot 2, apply 75 ticks, leave slot 2 -> next cycle mode=1, minutes=1, seconds=15, timing[2]=0.
REQ-033 After REQ-032, apply 5 more ticks -> mode=1 through tick 4; mode=0 and 00:00 after tick 5.
REQ-034 Park slot 0, apply 3600 ticks, leave slot 0 -> minutes=59, seconds=59 (saturated).
REQ-035 Leave slot 1 while it is idle -> mode stays 0 and timing unchanged. Park slot 3 twice, 10 ticks apart, then leave after 20 ticks total -> 00:20.
REQ-036 Park slot 1, apply 7 ticks; in one cycle assert park and leave on slot 1 plus tick -> display 00:07 and slot 1 restarts at 00:00. Assert reset during SHOW -> mode=0 and timing=0 immediately.
